// File: rtl/regfile_scoreboard.sv
// Register file with NRD combinational read ports and a per-register write-pending
// scoreboard. Issue claims set a pending bit, writeback clears it, and flush squashes
// all claims. Optional same-cycle writeback-to-read bypass under REGFILE_BYPASS_EN.
module regfile_scoreboard #(
    parameter int unsigned DWIDTH  = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned NRD     = 2,
    parameter logic [DWIDTH-1:0] SP_INIT = DWIDTH'(32'h0001_0000),
    localparam int unsigned AW     = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*AW-1:0]     rs_i,
    output logic [NRD*DWIDTH-1:0] rsdata_o,
    output logic [NRD-1:0]        rsbusy_o,
    input  logic                  iss_valid_i,
    input  logic [AW-1:0]         iss_rd_i,
    output logic                  iss_ready_o,
    input  logic                  wb_valid_i,
    input  logic [AW-1:0]         wb_rd_i,
    input  logic [DWIDTH-1:0]     wb_data_i,
    input  logic                  flush_i,
    output logic                  err_o
);

    logic [DWIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q, busy_d;
    logic              err_q, err_d;
    logic              wb_fire, claim_fire;

    // x0 writes are dropped entirely
    assign wb_fire = wb_valid_i && (wb_rd_i != '0);

    // A writeback landing on the claimed register frees it in time for the claim
    assign iss_ready_o = !busy_q[iss_rd_i] || (wb_valid_i && (wb_rd_i == iss_rd_i));
    assign claim_fire  = iss_valid_i && iss_ready_o && (iss_rd_i != '0);
    assign err_o       = err_q;

    // Scoreboard and sticky error next state; flush overrides any claim
    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        if (wb_fire) begin
            busy_d[wb_rd_i] = 1'b0;
            if (!busy_q[wb_rd_i] && !flush_i) begin
                err_d = 1'b1;
            end
        end
        if (claim_fire) begin
            busy_d[iss_rd_i] = 1'b1;
        end
        if (flush_i) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard and error state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    // Architectural register storage; x2 resets to the stack pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == 2) ? SP_INIT : '0;
            end
        end else if (wb_fire) begin
            regs_q[wb_rd_i] <= wb_data_i;
        end
    end

    // Combinational read ports, optionally forwarding the in-flight writeback
    always_comb begin
        rsdata_o = '0;
        rsbusy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            if (rs_i[k*AW +: AW] != '0) begin
                rsdata_o[k*DWIDTH +: DWIDTH] = regs_q[rs_i[k*AW +: AW]];
                rsbusy_o[k]                  = busy_q[rs_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
                if (wb_fire && (wb_rd_i == rs_i[k*AW +: AW])) begin
                    rsdata_o[k*DWIDTH +: DWIDTH] = wb_data_i;
                    rsbusy_o[k]                  = 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed test-plan steps followed by random traffic,
// all checked against an array-based reference model of the register file.
module tb_regfile_scoreboard;

    localparam int unsigned DW = 32;
    localparam int unsigned NR = 32;
    localparam int unsigned NP = 2;
    localparam int unsigned AW = 5;
    localparam logic [31:0] SP = 32'h0001_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP*AW-1:0]  rs_i;
    logic [NP*DW-1:0]  rsdata_o;
    logic [NP-1:0]     rsbusy_o;
    logic              iss_valid_i;
    logic [AW-1:0]     iss_rd_i;
    logic              iss_ready_o;
    logic              wb_valid_i;
    logic [AW-1:0]     wb_rd_i;
    logic [DW-1:0]     wb_data_i;
    logic              flush_i;
    logic              err_o;

    int n_vec  = 0;
    int n_fail = 0;

    logic [31:0] m_regs [NR];
    logic        m_busy [NR];
    logic        m_err;

`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    regfile_scoreboard #(
        .DWIDTH (DW),
        .NREGS  (NR),
        .NRD    (NP),
        .SP_INIT(SP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs_i       (rs_i),
        .rsdata_o   (rsdata_o),
        .rsbusy_o   (rsbusy_o),
        .iss_valid_i(iss_valid_i),
        .iss_rd_i   (iss_rd_i),
        .iss_ready_o(iss_ready_o),
        .wb_valid_i (wb_valid_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .flush_i    (flush_i),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = (i == 2) ? SP : 32'h0;
            m_busy[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    function automatic logic bypass_hit(input int idx);
        return Bypass && wb_valid_i && (idx != 0) && (int'(wb_rd_i) == idx);
    endfunction

    function automatic logic [31:0] exp_data(input int idx);
        if (idx == 0) return 32'h0;
        if (bypass_hit(idx)) return wb_data_i;
        return m_regs[idx];
    endfunction

    function automatic logic exp_busy(input int idx);
        if (idx == 0 || bypass_hit(idx)) return 1'b0;
        return m_busy[idx];
    endfunction

    function automatic logic exp_ready();
        return !m_busy[iss_rd_i] || (wb_valid_i && wb_rd_i == iss_rd_i);
    endfunction

    function automatic logic [31:0] port_data(input int k);
        return rsdata_o[k*DW +: DW];
    endfunction

    task automatic set_rs(input int a, input int b);
        rs_i = {AW'(b), AW'(a)};
    endtask

    task automatic idle();
        iss_valid_i = 1'b0;
        iss_rd_i    = '0;
        wb_valid_i  = 1'b0;
        wb_rd_i     = '0;
        wb_data_i   = '0;
        flush_i     = 1'b0;
    endtask

    // Compare all outputs against the model, clock once, then apply the rules to the model.
    task automatic step();
        logic rdy;
        #1;
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("rsdata%0d", k), port_data(k), exp_data(int'(rs_i[k*AW +: AW])));
            chk($sformatf("rsbusy%0d", k), rsbusy_o[k], exp_busy(int'(rs_i[k*AW +: AW])));
        end
        rdy = exp_ready();
        chk("iss_ready", iss_ready_o, rdy);
        chk("err", err_o, m_err);
        @(posedge clk);
        #1;
        if (wb_valid_i && wb_rd_i != 0) begin
            if (!m_busy[wb_rd_i] && !flush_i) m_err = 1'b1;
            m_regs[wb_rd_i] = wb_data_i;
            m_busy[wb_rd_i] = 1'b0;
        end
        if (iss_valid_i && rdy && iss_rd_i != 0) m_busy[iss_rd_i] = 1'b1;
        if (flush_i) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end
    endtask

    task automatic claim(input int r);
        idle();
        iss_valid_i = 1'b1;
        iss_rd_i    = AW'(r);
        step();
    endtask

    initial begin
        rst = 1'b0;
        idle();
        set_rs(2, 5);
        model_reset();
        #12;
        chk("reset_x2", port_data(0), 32'h0001_0000);
        chk("reset_x5", port_data(1), 32'h0);
        chk("reset_busy", rsbusy_o, 2'b00);
        chk("reset_ready", iss_ready_o, 1'b1);
        chk("reset_err", err_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Claim x7, stall a second claim, then write it back
        claim(7);
        idle();
        set_rs(7, 7);
        #1;
        chk("x7_busy", rsbusy_o[0], 1'b1);
        step();
        iss_valid_i = 1'b1;
        iss_rd_i    = 5'd7;
        #1;
        chk("x7_reclaim_stall", iss_ready_o, 1'b0);
        step();
        idle();
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd7;
        wb_data_i  = 32'hDEAD_BEEF;
        step();
        idle();
        #1;
        chk("x7_data", port_data(0), 32'hDEAD_BEEF);
        chk("x7_free", rsbusy_o[0], 1'b0);
        step();

        // Same-cycle writeback and re-claim of x9
        claim(9);
        idle();
        iss_valid_i = 1'b1;
        iss_rd_i    = 5'd9;
        wb_valid_i  = 1'b1;
        wb_rd_i     = 5'd9;
        wb_data_i   = 32'h1234;
        set_rs(9, 0);
        #1;
        chk("x9_same_ready", iss_ready_o, 1'b1);
        step();
        idle();
        #1;
        chk("x9_data", port_data(0), 32'h1234);
        chk("x9_busy", rsbusy_o[0], 1'b1);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd9;
        wb_data_i  = 32'h9;
        step();

        // Writeback to x3 while port 1 reads it
        claim(3);
        idle();
        set_rs(0, 3);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd3;
        wb_data_i  = 32'hA5A5_A5A5;
        #1;
        chk("x3_wb_cycle_data", port_data(1), Bypass ? 32'hA5A5_A5A5 : 32'h0);
        chk("x3_wb_cycle_busy", rsbusy_o[1], Bypass ? 1'b0 : 1'b1);
        step();
        idle();
        #1;
        chk("x3_after_data", port_data(1), 32'hA5A5_A5A5);
        chk("x3_after_busy", rsbusy_o[1], 1'b0);
        step();

        // x0 claim and writeback are dropped
        iss_valid_i = 1'b1;
        iss_rd_i    = 5'd0;
        wb_valid_i  = 1'b1;
        wb_rd_i     = 5'd0;
        wb_data_i   = 32'hFFFF_FFFF;
        set_rs(0, 0);
        #1;
        chk("x0_ready", iss_ready_o, 1'b1);
        step();
        idle();
        #1;
        chk("x0_data", port_data(0), 32'h0);
        chk("x0_busy", rsbusy_o[0], 1'b0);
        chk("x0_err", err_o, 1'b0);
        step();

        // Flush, then an unclaimed writeback raises the sticky error
        claim(4);
        claim(6);
        idle();
        set_rs(4, 6);
        #1;
        chk("pre_flush_busy", rsbusy_o, 2'b11);
        flush_i = 1'b1;
        step();
        idle();
        #1;
        chk("post_flush_busy", rsbusy_o, 2'b00);
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd4;
        wb_data_i  = 32'h0000_0044;
        #1;
        chk("err_not_yet", err_o, 1'b0);
        step();
        idle();
        #1;
        chk("err_set", err_o, 1'b1);
        chk("x4_written", port_data(0), 32'h0000_0044);
        step();

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            iss_valid_i = 1'($urandom_range(0, 1));
            iss_rd_i    = AW'($urandom_range(0, NR - 1));
            wb_valid_i  = 1'($urandom_range(0, 1));
            wb_rd_i     = ($urandom_range(0, 3) == 0) ? iss_rd_i : AW'($urandom_range(0, NR - 1));
            wb_data_i   = $urandom;
            flush_i     = ($urandom_range(0, 15) == 0);
            set_rs(int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)));
            step();
        end

        // Asynchronous reset while x8 is busy
        idle();
        wb_valid_i = 1'b1;
        wb_rd_i    = 5'd8;
        wb_data_i  = 32'h0808_0808;
        step();
        claim(8);
        idle();
        set_rs(8, 2);
        #1;
        chk("x8_busy_pre_rst", rsbusy_o[0], 1'b1);
        #1;
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_rst_x8_data", port_data(0), 32'h0);
        chk("async_rst_x8_busy", rsbusy_o[0], 1'b0);
        chk("async_rst_x2", port_data(1), SP);
        chk("async_rst_err", err_o, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
